// File: rtl/fa_bist_checker.sv
// ---------------------------------------------------------------------------
// fa_bist_checker
//
// Purpose:
//   On-chip BIST for 3-input gate / full-adder primitives. It drives all eight
//   {a,b,c} combinations, in ascending order, into a combinational DUT. It
//   samples the DUT's sum (x) and carry (y) and compares them against the
//   full-adder truth table. It then reports a pass/fail verdict, a saturating
//   error count and the first failing vector.
//
// Parameters:
//   SETTLE      extra cycles each vector is held before sampling (0..15)
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   start       begin a sweep (accepted only in IDLE)
//   a, b, c     registered stimulus to the DUT
//   x, y        DUT sum / carry outputs
//   busy        high while a sweep is in progress
//   done        one-cycle pulse when a sweep completes
//   pass        last sweep had zero errors (valid from done, held to next start)
//   err_count   mismatching vectors seen, saturating at 15
//   fail_valid  at least one mismatch recorded
//   fail_vec    {a,b,c} index of the first mismatching vector
//
// Build option:
//   FA_BIST_LOOP_EN  when defined, the block sweeps continuously after start.
//                    It pulses done at the end of every sweep and accumulates
//                    errors across sweeps. Only rst stops it.
// ---------------------------------------------------------------------------
module fa_bist_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // With no settle time a freshly driven vector is sampled on the very next edge.
    localparam state_t     FIRST_STATE = (SETTLE == 0) ? SAMPLE : HOLD;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q;
    logic [2:0] vec_q;      // vector index; also the value driven on {a,b,c}
    logic [3:0] settle_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] err_q;
    logic       fail_valid_q;
    logic [2:0] fail_vec_q;

    logic       exp_x;
    logic       exp_y;
    logic       mismatch;
    logic [3:0] err_d;

    // Golden full-adder response for the vector currently on the DUT inputs.
    always_comb begin
        exp_x    = vec_q[2] ^ vec_q[1] ^ vec_q[0];
        exp_y    = (vec_q[2] & vec_q[1]) | (vec_q[1] & vec_q[0]) | (vec_q[2] & vec_q[0]);
        mismatch = (x != exp_x) || (y != exp_y);
        err_d    = err_q;
        if (mismatch && (err_q != 4'd15)) begin
            err_d = err_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= 3'd0;
            settle_q     <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= 4'd0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 3'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q        <= 4'd0;
                        fail_valid_q <= 1'b0;
                        fail_vec_q   <= 3'd0;
                        pass_q       <= 1'b0;
                        vec_q        <= 3'd0;
                        settle_q     <= 4'd0;
                        busy_q       <= 1'b1;
                        state_q      <= FIRST_STATE;
                    end
                end
                HOLD: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    err_q <= err_d;
                    if (mismatch && !fail_valid_q) begin
                        fail_vec_q   <= vec_q;
                        fail_valid_q <= 1'b1;
                    end
                    if (vec_q != 3'd7) begin
                        vec_q    <= vec_q + 3'd1;
                        settle_q <= 4'd0;
                        state_q  <= FIRST_STATE;
                    end else begin
                        done_q <= 1'b1;
                        pass_q <= (err_d == 4'd0);
`ifdef FA_BIST_LOOP_EN
                        // Wrap straight back to vector 0 so back-to-back sweeps
                        // keep the same cadence; busy stays high.
                        vec_q    <= 3'd0;
                        settle_q <= 4'd0;
                        state_q  <= FIRST_STATE;
`else
                        busy_q  <= 1'b0;
                        state_q <= DONE;
`endif
                    end
                end
                DONE: begin
                    // done is high during this cycle; start here is dropped.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a          = vec_q[2];
    assign b          = vec_q[1];
    assign c          = vec_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule
